// File: rtl/bcd_pkg.sv
// Shared BCD constants, the per-edge operation select and nibble validation
// used by the N-digit BCD counter slice.
package bcd_pkg;

  localparam int unsigned BCD_NIBBLE_W  = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_STEP
  } bcd_op_e;

  function automatic logic bcd_nibble_valid(input logic [BCD_NIBBLE_W-1:0] n);
    return n <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement cell; carry_out flags a 9->0 (up)
// or 0->9 (down) transition so the next digit can step.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] digit,
  input  logic                    step,
  input  logic                    down,
  output logic [BCD_NIBBLE_W-1:0] digit_next,
  output logic                    carry_out
);

  always_comb begin
    digit_next = digit;
    carry_out  = 1'b0;
    if (step) begin
      if (down) begin
        if (digit == '0) begin
          digit_next = BCD_MAX_DIGIT;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end else begin
        if (digit >= BCD_MAX_DIGIT) begin
          digit_next = '0;
          carry_out  = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Registered N-digit packed-BCD up/down counter with clear, sanitising load,
// wrap/saturate mode, terminal-count pulse and leading-zero blank mask.
module bcd_counter_ndigit
  import bcd_pkg::*;
#(
  parameter int unsigned                    DIGITS      = 5,
  parameter bit                             SATURATE    = 1'b0,
  parameter logic [BCD_NIBBLE_W*DIGITS-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           load,
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] load_value,
  input  logic                           enable,
  input  logic                           down,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] count,
  output logic                           tc,
  output logic                           load_err,
  output logic [DIGITS-1:0]              blank_mask
);

  localparam int unsigned W = BCD_NIBBLE_W * DIGITS;

  logic [W-1:0]      count_q;
  logic [W-1:0]      count_nxt;
  logic [W-1:0]      stepped;
  logic [W-1:0]      loaded;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] carry;
  logic              load_bad;
  logic              tc_nxt;
  logic              err_nxt;
  bcd_op_e           op;

  // Bit i set when digits DIGITS-1..i are all zero; bit 0 never blanks.
  function automatic logic [DIGITS-1:0] blank_of(input logic [W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (v[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] == '0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

  assign step[0] = enable;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i > 0) begin : g_chain
      assign step[i] = carry[i-1];
    end
    bcd_digit_step u_step (
      .digit      (count_q[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .step       (step[i]),
      .down       (down),
      .digit_next (stepped[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .carry_out  (carry[i])
    );
  end

  // Invalid nibbles are forced to 0 so count never holds a non-BCD digit.
  always_comb begin
    loaded   = '0;
    load_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_nibble_valid(load_value[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]))
        loaded[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = load_value[i*BCD_NIBBLE_W +: BCD_NIBBLE_W];
      else
        load_bad = 1'b1;
    end
  end

  always_comb begin
    if (clear)       op = OP_CLEAR;
    else if (load)   op = OP_LOAD;
    else if (enable) op = OP_STEP;
    else             op = OP_HOLD;
  end

  always_comb begin
    count_nxt = count_q;
    tc_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (op)
      OP_CLEAR: count_nxt = '0;
      OP_LOAD: begin
        count_nxt = loaded;
        err_nxt   = load_bad;
      end
      OP_STEP: begin
        tc_nxt = carry[DIGITS-1];
        if (!(SATURATE && carry[DIGITS-1]))
          count_nxt = stepped;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= RESET_VALUE;
      tc         <= 1'b0;
      load_err   <= 1'b0;
      blank_mask <= blank_of(RESET_VALUE);
    end else begin
      count_q    <= count_nxt;
      tc         <= tc_nxt;
      load_err   <= err_nxt;
      blank_mask <= blank_of(count_nxt);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench: a wrap-mode counter driven from a vector table plus hand
// sequences for async reset and a saturate-mode counter.
module tb_bcd_counter_ndigit;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        w_clear = 1'b0, w_load = 1'b0, w_enable = 1'b0, w_down = 1'b0;
  logic [19:0] w_load_value = '0;
  logic [19:0] w_count;
  logic        w_tc, w_err;
  logic [4:0]  w_mask;

  logic        s_clear = 1'b0, s_load = 1'b0, s_enable = 1'b0, s_down = 1'b0;
  logic [19:0] s_load_value = '0;
  logic [19:0] s_count;
  logic        s_tc, s_err;
  logic [4:0]  s_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(5), .SATURATE(1'b0), .RESET_VALUE(20'h00000)) dut_w (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load),
    .load_value(w_load_value), .enable(w_enable), .down(w_down),
    .count(w_count), .tc(w_tc), .load_err(w_err), .blank_mask(w_mask)
  );

  bcd_counter_ndigit #(.DIGITS(5), .SATURATE(1'b1), .RESET_VALUE(20'h00500)) dut_s (
    .clk(clk), .reset(reset), .clear(s_clear), .load(s_load),
    .load_value(s_load_value), .enable(s_enable), .down(s_down),
    .count(s_count), .tc(s_tc), .load_err(s_err), .blank_mask(s_mask)
  );

  typedef struct {
    logic        clr;
    logic        ld;
    logic [19:0] lv;
    logic        en;
    logic        dn;
    logic [19:0] ec;
    logic        etc;
    logic        eerr;
    logic [4:0]  em;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_w(input logic clr, input logic ld, input logic [19:0] lv,
                         input logic en, input logic dn);
    @(negedge clk);
    w_clear = clr; w_load = ld; w_load_value = lv; w_enable = en; w_down = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic clr, input logic ld, input logic [19:0] lv,
                         input logic en, input logic dn);
    @(negedge clk);
    s_clear = clr; s_load = ld; s_load_value = lv; s_enable = en; s_down = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_s(input string nm, input logic [19:0] ec, input logic etc,
                       input logic [4:0] em);
    chk({nm, "_count"}, 32'(s_count), 32'(ec));
    chk({nm, "_tc"},    32'(s_tc),    32'(etc));
    chk({nm, "_mask"},  32'(s_mask),  32'(em));
  endtask

  initial begin
    //             clr ld  lv        en  dn  count     tc  err mask
    vecs[0]  = '{1'b0,1'b1,20'h09999,1'b0,1'b0,20'h09999,1'b0,1'b0,5'b10000};
    vecs[1]  = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h10000,1'b0,1'b0,5'b00000};
    vecs[2]  = '{1'b0,1'b1,20'h99999,1'b0,1'b0,20'h99999,1'b0,1'b0,5'b00000};
    vecs[3]  = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h00000,1'b1,1'b0,5'b11110};
    vecs[4]  = '{1'b0,1'b0,20'h00000,1'b0,1'b0,20'h00000,1'b0,1'b0,5'b11110};
    vecs[5]  = '{1'b0,1'b0,20'h00000,1'b1,1'b1,20'h99999,1'b1,1'b0,5'b00000};
    vecs[6]  = '{1'b0,1'b1,20'h1A2F3,1'b0,1'b0,20'h10203,1'b0,1'b1,5'b00000};
    vecs[7]  = '{1'b0,1'b0,20'h00000,1'b0,1'b0,20'h10203,1'b0,1'b0,5'b00000};
    vecs[8]  = '{1'b1,1'b1,20'h55555,1'b1,1'b0,20'h00000,1'b0,1'b0,5'b11110};
    vecs[9]  = '{1'b0,1'b1,20'h00123,1'b1,1'b0,20'h00123,1'b0,1'b0,5'b11000};
    vecs[10] = '{1'b0,1'b0,20'h00000,1'b1,1'b1,20'h00122,1'b0,1'b0,5'b11000};
    vecs[11] = '{1'b0,1'b1,20'h00100,1'b0,1'b0,20'h00100,1'b0,1'b0,5'b11000};
    vecs[12] = '{1'b0,1'b0,20'h00000,1'b1,1'b1,20'h00099,1'b0,1'b0,5'b11100};
    vecs[13] = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h00100,1'b0,1'b0,5'b11000};
    vecs[14] = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h00101,1'b0,1'b0,5'b11000};
    vecs[15] = '{1'b0,1'b0,20'h00000,1'b1,1'b1,20'h00100,1'b0,1'b0,5'b11000};
    vecs[16] = '{1'b0,1'b1,20'h0000F,1'b0,1'b0,20'h00000,1'b0,1'b1,5'b11110};
    vecs[17] = '{1'b1,1'b0,20'h00000,1'b0,1'b0,20'h00000,1'b0,1'b0,5'b11110};
    vecs[18] = '{1'b0,1'b1,20'hFFFFF,1'b1,1'b1,20'h00000,1'b0,1'b1,5'b11110};
    vecs[19] = '{1'b0,1'b0,20'h00000,1'b1,1'b1,20'h99999,1'b1,1'b0,5'b00000};
    vecs[20] = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h00000,1'b1,1'b0,5'b11110};
    vecs[21] = '{1'b0,1'b1,20'h00009,1'b0,1'b0,20'h00009,1'b0,1'b0,5'b11110};
    vecs[22] = '{1'b0,1'b0,20'h00000,1'b1,1'b0,20'h00010,1'b0,1'b0,5'b11100};

    // Reset state of both instances while reset is still held.
    #12;
    chk("rst_w_count", 32'(w_count), 32'h00000);
    chk("rst_w_tc",    32'(w_tc),    32'h0);
    chk("rst_w_err",   32'(w_err),   32'h0);
    chk("rst_w_mask",  32'(w_mask),  32'b11110);
    chk("rst_s_count", 32'(s_count), 32'h00500);
    chk("rst_s_mask",  32'(s_mask),  32'b11000);
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-count: must clear without a clock edge.
    drive_w(1'b0, 1'b1, 20'h01234, 1'b0, 1'b0);
    chk("pre_areset_count", 32'(w_count), 32'h01234);
    @(negedge clk);
    w_load = 1'b0; w_enable = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("areset_count", 32'(w_count), 32'h00000);
    chk("areset_mask",  32'(w_mask),  32'b11110);
    chk("areset_tc",    32'(w_tc),    32'h0);
    w_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive_w(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].dn);
      chk($sformatf("vec%0d_count", i), 32'(w_count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_tc", i),    32'(w_tc),    32'(vecs[i].etc));
      chk($sformatf("vec%0d_err", i),   32'(w_err),   32'(vecs[i].eerr));
      chk($sformatf("vec%0d_mask", i),  32'(w_mask),  32'(vecs[i].em));
    end
    drive_w(1'b0, 1'b0, 20'h00000, 1'b0, 1'b0);

    // Saturate-mode instance.
    drive_s(1'b0, 1'b1, 20'h99998, 1'b0, 1'b0);
    chk_s("sat_load", 20'h99998, 1'b0, 5'b00000);
    drive_s(1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
    chk_s("sat_to_max", 20'h99999, 1'b0, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      drive_s(1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
      chk_s($sformatf("sat_hold_up%0d", k), 20'h99999, 1'b1, 5'b00000);
    end
    drive_s(1'b0, 1'b0, 20'h00000, 1'b0, 1'b0);
    chk_s("sat_idle", 20'h99999, 1'b0, 5'b00000);
    drive_s(1'b1, 1'b0, 20'h00000, 1'b0, 1'b0);
    chk_s("sat_clear", 20'h00000, 1'b0, 5'b11110);
    drive_s(1'b0, 1'b0, 20'h00000, 1'b1, 1'b1);
    chk_s("sat_hold_down", 20'h00000, 1'b1, 5'b11110);
    drive_s(1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
    chk_s("sat_up_from_zero", 20'h00001, 1'b0, 5'b11110);
    chk("sat_err", 32'(s_err), 32'h0);
    drive_s(1'b0, 1'b0, 20'h00000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
